// File: rtl/btn_debounce_counter.sv
// Pushbutton debouncer with press counter.
// Raw active-low BTN_N is synchronized, debounced by a four-state FSM, and
// converted into single-cycle press/release strobes plus a 7-bit press count.
// Optional feature: define BTN_AUTOREPEAT_EN to emit repeated press strobes
// while the button stays held (first after HOLD_CYCLES, then every
// REPEAT_CYCLES).
module btn_debounce_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned HOLD_CYCLES     = 8000000,
  parameter int unsigned REPEAT_CYCLES   = 2000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_N,
  input  logic       count_clr,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [6:0] count
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  // Elaboration-time parameter legality checks.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..2^20");
  end
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
  end

  state_t          state;
  state_t          next_state;
  logic [1:0]      sync;
  logic            pressed;
  logic [DB_W-1:0] db_cnt;
  logic            db_done;
  logic            press_set;
  logic            release_set;
  logic            rpt_fire;
  logic            press_q;
  logic            release_q;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RST) sync <= 2'b11;
    else     sync <= {sync[0], BTN_N};
  end

  assign pressed = ~sync[1];
  assign db_done = (db_cnt == DB_W'(DEBOUNCE_CYCLES));

  // State register plus the registered strobes that mark the first cycle of
  // HELD (press) or IDLE (release).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state     <= next_state;
      press_q   <= press_set;
      release_q <= release_set;
    end
  end

  // Next-state logic: any opposite sample inside a wait state aborts it.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      IDLE:         if (pressed) next_state = PRESS_WAIT;
      PRESS_WAIT:   if (!pressed) next_state = IDLE;
                    else if (db_done) next_state = HELD;
      HELD:         if (!pressed) next_state = RELEASE_WAIT;
      RELEASE_WAIT: if (pressed) next_state = HELD;
                    else if (db_done) next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  assign press_set   = ((state == PRESS_WAIT) && (next_state == HELD)) || rpt_fire;
  assign release_set = (state == RELEASE_WAIT) && (next_state == IDLE);

  // Debounce counter: counts consecutive stable samples inside a wait state,
  // cleared whenever the FSM changes state or rests in IDLE/HELD.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      db_cnt <= '0;
    end else if ((state != next_state) || (state == IDLE) || (state == HELD)) begin
      db_cnt <= '0;
    end else if (!db_done) begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_limit;
  logic             rpt_first_done;

  // First repeat waits HOLD_CYCLES, later ones REPEAT_CYCLES.
  assign rpt_limit = rpt_first_done ? RPT_W'(REPEAT_CYCLES - 1) : RPT_W'(HOLD_CYCLES - 1);
  assign rpt_fire  = (state == HELD) && (next_state == HELD) && (rpt_cnt == rpt_limit);

  // Repeat timer: cleared on a fresh press, runs only while staying in HELD,
  // and holds its value through RELEASE_WAIT so a bounce resumes it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rpt_cnt        <= '0;
      rpt_first_done <= 1'b0;
    end else if ((state == PRESS_WAIT) && (next_state == HELD)) begin
      rpt_cnt        <= '0;
      rpt_first_done <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt        <= '0;
      rpt_first_done <= 1'b1;
    end else if ((state == HELD) && (next_state == HELD)) begin
      rpt_cnt        <= rpt_cnt + RPT_W'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Press counter: bumps on the edge that raises press_pulse; clear wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            count <= '0;
    else if (count_clr) count <= '0;
    else if (press_set) count <= count + 7'd1;
  end

  // Outputs decoded from state and the registered strobes.
  always_comb begin
    btn_level     = (state == HELD) || (state == RELEASE_WAIT);
    press_pulse   = press_q;
    release_pulse = release_q;
  end

endmodule

// File: tb/tb_btn_debounce_counter.sv
// Directed testbench for btn_debounce_counter (DEBOUNCE=4, HOLD=20, REPEAT=8).
// Build with +define+BTN_AUTOREPEAT_EN to exercise the auto-repeat variant.
module tb_btn_debounce_counter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN_N;
  logic       count_clr;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [6:0] count;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] exp_count;

  btn_debounce_counter #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .BTN_N        (BTN_N),
    .count_clr    (count_clr),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .count        (count)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Press from IDLE: BTN_N low sampled on edge 0, strobe expected on edge 7.
  task automatic do_press(input string tag, input bit clr_on_pulse);
    BTN_N = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k < 6) check({tag, "_early"}, {31'd0, press_pulse}, 32'd0);
    end
    if (clr_on_pulse) count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    exp_count = clr_on_pulse ? 7'd0 : exp_count + 7'd1;
    check({tag, "_pulse"}, {31'd0, press_pulse}, 32'd1);
    check({tag, "_count"}, {25'd0, count}, {25'd0, exp_count});
  endtask

  // Clean release from HELD: strobe expected on the 8th edge.
  task automatic do_release(input string tag);
    BTN_N = 1'b1;
    repeat (7) tick();
    check({tag, "_rel_early"}, {31'd0, release_pulse}, 32'd0);
    tick();
    check({tag, "_rel_pulse"}, {31'd0, release_pulse}, 32'd1);
    check({tag, "_rel_level"}, {31'd0, btn_level}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; BTN_N = 1'b1; count_clr = 1'b0; exp_count = 7'd0;
    repeat (3) tick();
    check("rst_level", {31'd0, btn_level}, 32'd0);
    check("rst_press", {31'd0, press_pulse}, 32'd0);
    check("rst_release", {31'd0, release_pulse}, 32'd0);
    check("rst_count", {25'd0, count}, 32'd0);
    RST = 1'b0;
    repeat (2) tick();

    // Basic press latency and release.
    do_press("press1", 1'b0);
    check("press1_level", {31'd0, btn_level}, 32'd1);
    tick();
    check("press1_single", {31'd0, press_pulse}, 32'd0);
    do_release("press1");

    // Three-cycle glitch must be ignored.
    BTN_N = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) BTN_N = 1'b1;
      tick();
      check("glitch_press", {31'd0, press_pulse}, 32'd0);
      check("glitch_level", {31'd0, btn_level}, 32'd0);
    end
    check("glitch_count", {25'd0, count}, {25'd0, exp_count});

    // Release with a two-cycle bounce back to pressed inside RELEASE_WAIT.
    do_press("bounce", 1'b0);
    BTN_N = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 2) BTN_N = 1'b0;
      if (k == 4) BTN_N = 1'b1;
      tick();
      check("bounce_no_rel", {31'd0, release_pulse}, 32'd0);
    end
    check("bounce_level_held", {31'd0, btn_level}, 32'd1);
    tick();
    check("bounce_rel_pulse", {31'd0, release_pulse}, 32'd1);
    check("bounce_rel_level", {31'd0, btn_level}, 32'd0);
    tick();
    check("bounce_rel_single", {31'd0, release_pulse}, 32'd0);

    // Reset on the third cycle of PRESS_WAIT abandons the press.
    BTN_N = 1'b0;
    repeat (5) tick();
    RST = 1'b1; BTN_N = 1'b1;
    #1;
    check("midrst_count", {25'd0, count}, 32'd0);
    check("midrst_level", {31'd0, btn_level}, 32'd0);
    check("midrst_press", {31'd0, press_pulse}, 32'd0);
    exp_count = 7'd0;
    repeat (2) tick();
    RST = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("postrst_press", {31'd0, press_pulse}, 32'd0);
      check("postrst_release", {31'd0, release_pulse}, 32'd0);
    end
    check("postrst_level", {31'd0, btn_level}, 32'd0);

    // Button held through reset deassertion gives exactly one press.
    RST = 1'b1; BTN_N = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    do_press("heldrst", 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("heldrst_single", {31'd0, press_pulse}, 32'd0);
    end
    do_release("heldrst");

    // Count wrap: fill to 127, one more press wraps to 0.
    for (int n = 0; n < 126; n++) begin
      do_press("fill", 1'b0);
      do_release("fill");
    end
    check("fill_127", {25'd0, count}, 32'd127);
    do_press("wrap", 1'b0);
    check("wrap_zero", {25'd0, count}, 32'd0);
    do_release("wrap");
    do_press("inc_after_wrap", 1'b0);
    do_release("inc_after_wrap");

    // Clear on the press edge wins but the strobe still fires.
    do_press("clr", 1'b1);
    check("clr_count", {25'd0, count}, 32'd0);
    do_release("clr");

    // Long hold: auto-repeat strobes only when the feature is built in.
    do_press("hold", 1'b0);
    for (int i = 1; i <= 60; i++) begin
      logic exp_p;
      if (i == 57) BTN_N = 1'b1;
      tick();
`ifdef BTN_AUTOREPEAT_EN
      exp_p = (i == 20) || (i == 28) || (i == 36) || (i == 44) || (i == 52);
      if (exp_p) exp_count = exp_count + 7'd1;
`else
      exp_p = 1'b0;
`endif
      check("hold_pulse", {31'd0, press_pulse}, {31'd0, exp_p});
    end
`ifdef BTN_AUTOREPEAT_EN
    check("hold_count", {25'd0, count}, 32'd6);
`else
    check("hold_count", {25'd0, count}, 32'd1);
`endif
    check("hold_count_model", {25'd0, count}, {25'd0, exp_count});
    repeat (3) tick();
    check("hold_rel_early", {31'd0, release_pulse}, 32'd0);
    tick();
    check("hold_rel_pulse", {31'd0, release_pulse}, 32'd1);
    check("hold_rel_level", {31'd0, btn_level}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_debounce_counter.md
BTN_DEBOUNCE_COUNTER -- requirements
Module: btn_debounce_counter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 65536, number of consecutive stable synchronized samples required to accept a level change (legal range 2..2^20).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8000000, cycles held in HELD before the first auto-repeat; used only when BTN_AUTOREPEAT_EN is defined.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 2000000, cycles between auto-repeats; used only when BTN_AUTOREPEAT_EN is defined.
REQ-004 SHALL have port CLK, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port BTN_N, input, 1 bit: raw asynchronous pushbutton, active-low (0 = pressed).
REQ-007 SHALL have port count_clr, input, 1 bit: synchronous clear of count.
REQ-008 SHALL have port btn_level, output, 1 bit: debounced pressed state (1 = pressed).
REQ-009 SHALL have port press_pulse, output, 1 bit: single-cycle strobe per accepted press or auto-repeat.
REQ-010 SHALL have port release_pulse, output, 1 bit: single-cycle strobe per accepted release.
REQ-011 SHALL have port count, output, 7 bits: press count, drives the segment display path directly.

Function
REQ-012 SHALL pass BTN_N through a 2-flop synchronizer; the inverted synchronizer output is "pressed"; no other logic samples BTN_N.
REQ-013 SHALL implement FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT with a debounce counter wide enough for DEBOUNCE_CYCLES.
REQ-014 IDLE: pressed=1 -> PRESS_WAIT, counter cleared; otherwise stay.
REQ-015 PRESS_WAIT: pressed=0 on any cycle -> IDLE with no pulse; DEBOUNCE_CYCLES consecutive pressed=1 samples -> HELD.
REQ-016 HELD: pressed=0 -> RELEASE_WAIT, counter cleared; otherwise stay.
REQ-017 RELEASE_WAIT: pressed=1 on any cycle -> HELD with no pulse; DEBOUNCE_CYCLES consecutive pressed=0 samples -> IDLE.
REQ-018 press_pulse SHALL be 1 for exactly the first cycle the FSM is in HELD after PRESS_WAIT; release_pulse SHALL be 1 for exactly the first cycle in IDLE after RELEASE_WAIT.
REQ-019 Total latency: press_pulse asserts DEBOUNCE_CYCLES+3 rising edges after the first edge sampling BTN_N=0, given BTN_N stays 0.
REQ-020 btn_level SHALL be 1 in HELD and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-021 count SHALL increment by 1 on the edge that asserts press_pulse, so the new value is visible in the same cycle as the pulse; 127 wraps to 0.
REQ-022 count_clr=1 SHALL set count to 0 on the next edge, with priority over a simultaneous increment; press_pulse is still emitted.
REQ-023 Glitches shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no pulse and no count change.

Reset
REQ-024 RST=1 SHALL asynchronously force: FSM=IDLE, debounce and repeat counters=0, synchronizer flops=1 (released), count=0, btn_level=0, press_pulse=0, release_pulse=0.
REQ-025 RST asserted mid-debounce or mid-hold SHALL abandon the operation without emitting any pulse.
REQ-026 A button held through RST deassertion SHALL be debounced normally and produce one press_pulse.

Configuration
REQ-027 Macro BTN_AUTOREPEAT_EN defined: after HOLD_CYCLES continuous cycles in HELD, emit press_pulse (and count increment), then one more every REPEAT_CYCLES while in HELD; the repeat timer clears on entry to HELD and is frozen in RELEASE_WAIT, and returning to HELD from RELEASE_WAIT resumes it.
REQ-028 Macro BTN_AUTOREPEAT_EN undefined: exactly one press_pulse per accepted press regardless of hold time; no repeat timer logic is synthesized.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-029 Drive BTN_N=0 from edge 0 and hold -> press_pulse=1 exactly at edge 7 for one cycle, count 0->1, btn_level=1.
REQ-030 Drive BTN_N=0 for 3 cycles, then 1 -> no press_pulse, count stays 0, FSM returns to IDLE.
REQ-031 Preload count=127 via 127 presses, press once more -> count=0; assert count_clr on the press_pulse edge -> count=0 and press_pulse=1.
REQ-032 Assert RST at the 3rd cycle of PRESS_WAIT, release RST with BTN_N=1 -> no pulse, all outputs 0; then hold BTN_N=0 through RST release -> one press_pulse after debounce.
REQ-033 Release after held press, with a 2-cycle bounce to 0 inside RELEASE_WAIT -> no release_pulse until 4 clean samples, then exactly one release_pulse, btn_level=0.
REQ-034 With BTN_AUTOREPEAT_EN, hold 60 cycles after press -> press_pulses at press, +20, +28, +36, +44, +52; count=6; without the macro count=1.
